// File: rtl/mac_cyv_pkg.sv
// Shared types and arithmetic helpers for the synapse-chain MAC.
// Arithmetic helpers work on 64-bit sign-extended containers. The caller
// passes the real operand width as an argument.
package mac_cyv_pkg;

   typedef enum logic [1:0] {
      MODE_CHAIN = 2'd0,
      MODE_ACC   = 2'd1,
      MODE_LOAD  = 2'd2
   } mode_t;

   localparam int unsigned CONT_W     = 64;
   localparam int unsigned CONT_IDX_W = $clog2(CONT_W);

   // Narrow a sign-extended value to `width` bits.
   // Returns {ovf, value sign-extended from the narrowed width}.
   function automatic logic [CONT_W:0] sat_narrow(input logic [CONT_W-1:0] value,
                                                  input int width,
                                                  input logic saturate);
      logic                  ovf;
      logic [CONT_W-1:0]     res;
      logic [CONT_W-1:0]     min_v;
      logic [CONT_IDX_W-1:0] top_idx;
      top_idx = CONT_IDX_W'(width - 1);
      ovf     = 1'b0;
      for (int i = 0; i < int'(CONT_W); i++) begin
         // Every bit from the target sign bit upward must match the true sign.
         if ((i + 1 >= width) && (value[i] != value[CONT_W-1])) begin
            ovf = 1'b1;
         end
         res[i] = (i < width) ? value[i] : value[top_idx];
      end
      min_v = {CONT_W{1'b1}} << top_idx;
      if (ovf && saturate) begin
         res = value[CONT_W-1] ? min_v : ~min_v;
      end
      return {ovf, res};
   endfunction

   // Add two sign-extended `width`-bit values; returns {ovf, result}.
   // The 64-bit sum is exact, so it overflows `width` bits exactly when the
   // operand signs agree and the result sign differs.
   function automatic logic [CONT_W:0] sat_add(input logic [CONT_W-1:0] a,
                                               input logic [CONT_W-1:0] b,
                                               input int width,
                                               input logic saturate);
      logic [CONT_W-1:0] sum;
      sum = a + b;
      return sat_narrow(sum, width, saturate);
   endfunction

endpackage

// File: rtl/mac_cyv_float2fixed.sv
// Float2Fixed: IEEE-style float to signed fixed point with InRadixPoint
// fractional bits. Truncates toward zero.
// exc_o flags inf/NaN. ovf_o flags a magnitude that does not fit.
module mac_cyv_float2fixed #(
   parameter int unsigned FloatSize    = 16,
   parameter int unsigned MantissaBits = 10,
   parameter int unsigned ExponentBits = 5,
   parameter int unsigned FixedSize    = 20,
   parameter int unsigned InRadixPoint = 10
) (
   input  logic [FloatSize-1:0] float_i,
   output logic [FixedSize-1:0] fixed_o,
   output logic                 exc_o,
   output logic                 ovf_o
);

   localparam int          Bias = (1 << (ExponentBits - 1)) - 1;
   localparam int unsigned ExtW = MantissaBits + 1 + FixedSize;

   logic                    sign;
   logic [ExponentBits-1:0] exp_f;
   logic [MantissaBits-1:0] man;
   logic [ExtW-1:0]         ext;
   logic [ExtW-1:0]         shifted;
   logic [FixedSize-2:0]    mag;
   int                      sh;

   // Decode fields, align the significand to the radix point, check range.
   always_comb begin
      sign    = float_i[FloatSize-1];
      exp_f   = float_i[MantissaBits +: ExponentBits];
      man     = float_i[MantissaBits-1:0];
      exc_o   = &exp_f;
      ovf_o   = 1'b0;
      shifted = '0;
      // A zero exponent is denormal: there is no hidden bit and the effective exponent is 1.
      ext = {{FixedSize{1'b0}}, (exp_f != '0), man};
      sh  = ((exp_f == '0) ? 1 : int'(exp_f)) - Bias - int'(MantissaBits) + int'(InRadixPoint);
      if (sh >= int'(FixedSize)) begin
         ovf_o = |ext;
      end else if (sh >= 0) begin
         shifted = ext << sh;
         ovf_o   = |shifted[ExtW-1:FixedSize-1];
      end else if (-sh < int'(ExtW)) begin
         shifted = ext >> (-sh);
      end
      mag     = shifted[FixedSize-2:0];
      fixed_o = sign ? -{1'b0, mag} : {1'b0, mag};
   end

endmodule

// File: rtl/mac_cyv_sat_add.sv
// Width-parametrised signed adder with overflow flag and optional clamping.
module mac_cyv_sat_add
   import mac_cyv_pkg::*;
#(
   parameter int unsigned Width    = 32,
   parameter bit          Saturate = 1'b1
) (
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   output logic [Width-1:0] sum_o,
   output logic             ovf_o
);

   logic [CONT_W:0] add_r;
   logic            unused_add_hi;

   // Sign-extend into the shared container and add.
   always_comb begin
      add_r = sat_add({{(CONT_W - Width){a_i[Width-1]}}, a_i},
                      {{(CONT_W - Width){b_i[Width-1]}}, b_i},
                      int'(Width), Saturate);
      sum_o = add_r[Width-1:0];
      ovf_o = add_r[CONT_W];
   end

   assign unused_add_hi = ^add_r[CONT_W-1:Width];

endmodule

// File: rtl/mac_cyv_param.sv
// Four-stage float multiply-accumulate cell for the synapse array.
// Computes q = a*b + c (chain) or acc += a*b, with saturation and error flags.
module mac_cyv_param
   import mac_cyv_pkg::*;
#(
   parameter int unsigned FLOATSIZE    = 16,
   parameter int unsigned MANTISSABITS = 10,
   parameter int unsigned EXPONENTBITS = 5,
   parameter int unsigned FIXEDSIZE    = 20,
   parameter int unsigned RADIX        = 10,
   parameter int unsigned ACCSIZE      = 32,
   parameter int unsigned SATURATE     = 1
) (
   input  logic                 clk,
   input  logic                 areset_n,
   input  logic                 en,
   input  logic                 valid_in,
   input  logic [1:0]           mode,
   input  logic [FLOATSIZE-1:0] a,
   input  logic [FLOATSIZE-1:0] b,
   input  logic [ACCSIZE-1:0]   c,
   input  logic                 clr_sticky,
   output logic [ACCSIZE-1:0]   q,
   output logic                 valid_out,
   output logic                 ovf_out,
   output logic                 exc_out,
   output logic                 ovf_sticky,
   output logic                 exc_sticky
);

   localparam int unsigned ProdW = 2 * FIXEDSIZE;

   // Operand conversion
   logic [FIXEDSIZE-1:0] a_fx, b_fx;
   logic                 a_exc, a_ovf, b_exc, b_ovf;

   // S1 registers
   logic [FIXEDSIZE-1:0] a_fx_d, a_fx_q, b_fx_d, b_fx_q;
   logic [ACCSIZE-1:0]   c1_d, c1_q;
   logic [1:0]           mode1_d, mode1_q;
   logic                 v1_d, v1_q, exc1_d, exc1_q;

   // S2 registers
   logic [ProdW-1:0]     p_d, p_q;
   logic [ACCSIZE-1:0]   c2_d, c2_q;
   logic [1:0]           mode2_d, mode2_q;
   logic                 v2_d, v2_q, exc2_d, exc2_q;

   // S3 registers and accumulator
   logic [CONT_W:0]      narrow_r;
   logic [ACCSIZE-1:0]   p_narrow, addend, sum_s;
   logic                 narrow_ovf, add_ovf, unused_narrow_hi;
   logic [ACCSIZE-1:0]   sum_d, sum_q, acc_d, acc_q;
   logic                 v3_d, v3_q, ovf3_d, ovf3_q, exc3_d, exc3_q;

   // S4 / output registers
   logic [ACCSIZE-1:0]   q_d, q_q;
   logic                 valid_out_d, valid_out_q, ovf_out_d, ovf_out_q;
   logic                 exc_out_d, exc_out_q;
   logic                 ovf_sticky_d, ovf_sticky_q, exc_sticky_d, exc_sticky_q;

   mac_cyv_float2fixed #(
      .FloatSize   (FLOATSIZE),
      .MantissaBits(MANTISSABITS),
      .ExponentBits(EXPONENTBITS),
      .FixedSize   (FIXEDSIZE),
      .InRadixPoint(RADIX)
   ) u_f2f_a (
      .float_i(a),
      .fixed_o(a_fx),
      .exc_o  (a_exc),
      .ovf_o  (a_ovf)
   );

   mac_cyv_float2fixed #(
      .FloatSize   (FLOATSIZE),
      .MantissaBits(MANTISSABITS),
      .ExponentBits(EXPONENTBITS),
      .FixedSize   (FIXEDSIZE),
      .InRadixPoint(RADIX)
   ) u_f2f_b (
      .float_i(b),
      .fixed_o(b_fx),
      .exc_o  (b_exc),
      .ovf_o  (b_ovf)
   );

   // S1: capture converted operands, zeroing any operand that failed conversion
   always_comb begin
      a_fx_d  = a_fx_q;
      b_fx_d  = b_fx_q;
      c1_d    = c1_q;
      mode1_d = mode1_q;
      v1_d    = v1_q;
      exc1_d  = exc1_q;
      if (en) begin
         a_fx_d  = (a_exc || a_ovf) ? '0 : a_fx;
         b_fx_d  = (b_exc || b_ovf) ? '0 : b_fx;
         c1_d    = c;
         mode1_d = mode;
         v1_d    = valid_in;
         exc1_d  = a_exc | a_ovf | b_exc | b_ovf;
      end
   end

   // S2: full-width signed product (truncated unsigned multiply of sign-extended operands)
   always_comb begin
      p_d     = p_q;
      c2_d    = c2_q;
      mode2_d = mode2_q;
      v2_d    = v2_q;
      exc2_d  = exc2_q;
      if (en) begin
         p_d     = {{FIXEDSIZE{a_fx_q[FIXEDSIZE-1]}}, a_fx_q} *
                   {{FIXEDSIZE{b_fx_q[FIXEDSIZE-1]}}, b_fx_q};
         c2_d    = c1_q;
         mode2_d = mode1_q;
         v2_d    = v1_q;
         exc2_d  = exc1_q;
      end
   end

   // S3 datapath: narrow the product, then pick the addend by mode
   always_comb begin
      narrow_r   = sat_narrow({{(CONT_W - ProdW){p_q[ProdW-1]}}, p_q}, int'(ACCSIZE),
                              SATURATE != 0);
      p_narrow   = narrow_r[ACCSIZE-1:0];
      narrow_ovf = narrow_r[CONT_W];
      // Reserved mode 3 falls through to the chain addend.
      addend     = (mode2_q == MODE_ACC) ? acc_q : c2_q;
   end

   assign unused_narrow_hi = ^narrow_r[CONT_W-1:ACCSIZE];

   mac_cyv_sat_add #(
      .Width   (ACCSIZE),
      .Saturate(SATURATE != 0)
   ) u_sat_add (
      .a_i  (p_narrow),
      .b_i  (addend),
      .sum_o(sum_s),
      .ovf_o(add_ovf)
   );

   // S3: register the sum. The accumulator updates here, so the next ACC sample
   // reads the new value one cycle later without forwarding.
   always_comb begin
      sum_d  = sum_q;
      ovf3_d = ovf3_q;
      exc3_d = exc3_q;
      v3_d   = v3_q;
      acc_d  = acc_q;
      if (en) begin
         v3_d = v2_q;
         if (v2_q) begin
            sum_d  = sum_s;
            ovf3_d = narrow_ovf | add_ovf;
            exc3_d = exc2_q;
            if ((mode2_q == MODE_ACC) || (mode2_q == MODE_LOAD)) begin
               acc_d = sum_s;
            end
         end
      end
   end

   // S4: q and its flags hold the last valid result.
   // The sticky flags set as a flagged result is loaded, and the set beats clr_sticky.
   always_comb begin
      q_d         = q_q;
      valid_out_d = valid_out_q;
      ovf_out_d   = ovf_out_q;
      exc_out_d   = exc_out_q;
      if (en) begin
         valid_out_d = v3_q;
         if (v3_q) begin
            q_d       = sum_q;
            ovf_out_d = ovf3_q;
            exc_out_d = exc3_q;
         end
      end
      ovf_sticky_d = (ovf_sticky_q & ~clr_sticky) | (en & v3_q & ovf3_q);
      exc_sticky_d = (exc_sticky_q & ~clr_sticky) | (en & v3_q & exc3_q);
   end

   // All state registers, asynchronously cleared
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         a_fx_q       <= '0;
         b_fx_q       <= '0;
         c1_q         <= '0;
         mode1_q      <= '0;
         v1_q         <= 1'b0;
         exc1_q       <= 1'b0;
         p_q          <= '0;
         c2_q         <= '0;
         mode2_q      <= '0;
         v2_q         <= 1'b0;
         exc2_q       <= 1'b0;
         sum_q        <= '0;
         ovf3_q       <= 1'b0;
         exc3_q       <= 1'b0;
         v3_q         <= 1'b0;
         acc_q        <= '0;
         q_q          <= '0;
         valid_out_q  <= 1'b0;
         ovf_out_q    <= 1'b0;
         exc_out_q    <= 1'b0;
         ovf_sticky_q <= 1'b0;
         exc_sticky_q <= 1'b0;
      end else begin
         a_fx_q       <= a_fx_d;
         b_fx_q       <= b_fx_d;
         c1_q         <= c1_d;
         mode1_q      <= mode1_d;
         v1_q         <= v1_d;
         exc1_q       <= exc1_d;
         p_q          <= p_d;
         c2_q         <= c2_d;
         mode2_q      <= mode2_d;
         v2_q         <= v2_d;
         exc2_q       <= exc2_d;
         sum_q        <= sum_d;
         ovf3_q       <= ovf3_d;
         exc3_q       <= exc3_d;
         v3_q         <= v3_d;
         acc_q        <= acc_d;
         q_q          <= q_d;
         valid_out_q  <= valid_out_d;
         ovf_out_q    <= ovf_out_d;
         exc_out_q    <= exc_out_d;
         ovf_sticky_q <= ovf_sticky_d;
         exc_sticky_q <= exc_sticky_d;
      end
   end

   assign q          = q_q;
   assign valid_out  = valid_out_q;
   assign ovf_out    = ovf_out_q;
   assign exc_out    = exc_out_q;
   assign ovf_sticky = ovf_sticky_q;
   assign exc_sticky = exc_sticky_q;

endmodule
